// File: rtl/decode_pkg.sv
// Shared opcodes, immediate kinds and ID/EX control bundle for the decode stage.
// Used by decode_stage and imm_gen.
package decode_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   typedef enum logic [2:0] {
      IMM_NONE = 3'd0,
      I        = 3'd1,
      S        = 3'd2,
      B        = 3'd3,
      U        = 3'd4,
      J        = 3'd5
   } imm_kind_t;

   // XLEN-independent part of the registered bundle; data fields live beside it in the stage.
   typedef struct packed {
      logic [31:0] instr;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        equal;
   } id_ex_t;

   function automatic logic uses_rs1(input imm_kind_t kind);
      return (kind != U) && (kind != J);
   endfunction

   function automatic logic uses_rs2(input logic [6:0] op);
      return (op == OP_STORE) || (op == OP_BRANCH) || (op == OP_REG);
   endfunction

endpackage

// File: rtl/decode_if.sv
// Fetch-side and execute-side handshake/bundle signals of the decode stage.
// The decode stage uses the slave modport; its environment uses master.
interface decode_if #(
   parameter int XLEN = 64,
   parameter int PC_W = 12
);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [PC_W-1:0] in_pc;
   logic            out_valid;
   logic            out_ready;
   logic [PC_W-1:0] ex_pc;
   logic [31:0]     ex_instr;
   logic [XLEN-1:0] ex_rs1_data;
   logic [XLEN-1:0] ex_rs2_data;
   logic [XLEN-1:0] ex_imm;
   logic [4:0]      ex_rd;
   logic [4:0]      ex_rs1;
   logic [4:0]      ex_rs2;
   logic [PC_W-1:0] ex_target;
   logic            ex_equal;

   modport slave (
      input  in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, ex_pc, ex_instr, ex_rs1_data, ex_rs2_data,
             ex_imm, ex_rd, ex_rs1, ex_rs2, ex_target, ex_equal
   );

   modport master (
      output in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, ex_pc, ex_instr, ex_rs1_data, ex_rs2_data,
             ex_imm, ex_rd, ex_rs1, ex_rs2, ex_target, ex_equal
   );
endinterface

// File: rtl/imm_gen.sv
// Opcode-to-immediate-format decode and sign extension of the immediate to XLEN.
module imm_gen
   import decode_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [31:0]     instr,
   output imm_kind_t       kind,
   output logic [XLEN-1:0] imm
);
   logic [31:0] imm32;

   // Classify the opcode into an immediate format.
   always_comb begin
      case (instr[6:0])
         OP_LOAD, OP_IMM, OP_JALR: kind = I;
         OP_STORE:                 kind = S;
         OP_BRANCH:                kind = B;
         OP_LUI, OP_AUIPC:         kind = U;
         OP_JAL:                   kind = J;
         default:                  kind = IMM_NONE;
      endcase
   end

   // Assemble the 32-bit immediate; B and J already carry their implicit zero LSB.
   always_comb begin
      case (kind)
         I:       imm32 = {{20{instr[31]}}, instr[31:20]};
         S:       imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         B:       imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         U:       imm32 = {instr[31:12], 12'd0};
         J:       imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm32 = 32'd0;
      endcase
   end

   assign imm = XLEN'($signed(imm32));
endmodule

// File: rtl/decode_stage.sv
// RISC-V decode stage: register file, immediate/target generation, ID/EX register,
// load-use interlock and flush. Define DECODE_WB_BYPASS_EN to bypass same-cycle writebacks.
module decode_stage
   import decode_pkg::*;
#(
   parameter int XLEN = 64,
   parameter int PC_W = 12
) (
   input  logic            clk,
   input  logic            rst,
   decode_if.slave         bus,
   input  logic            wb_en,
   input  logic [4:0]      wb_addr,
   input  logic [XLEN-1:0] wb_data,
   input  logic            flush,
   output logic [31:0]     stall_cnt
);
   logic [XLEN-1:0] regs [32];

   id_ex_t          ex_r;
   logic            valid_r;
   logic [PC_W-1:0] pc_r;
   logic [PC_W-1:0] target_r;
   logic [XLEN-1:0] rs1_data_r;
   logic [XLEN-1:0] rs2_data_r;
   logic [XLEN-1:0] imm_r;
   logic [31:0]     stall_r;

   imm_kind_t       kind_s;
   logic [XLEN-1:0] imm_s;
   logic [XLEN-1:0] rs1_data_s;
   logic [XLEN-1:0] rs2_data_s;
   logic [4:0]      rs1_s;
   logic [4:0]      rs2_s;
   logic            hazard_s;
   logic            advance_s;

   assign rs1_s = bus.in_instr[19:15];
   assign rs2_s = bus.in_instr[24:20];

   imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .instr (bus.in_instr),
      .kind  (kind_s),
      .imm   (imm_s)
   );

   // Operand reads; x0 is hard-wired to zero.
   always_comb begin
      if (rs1_s == 5'd0) rs1_data_s = {XLEN{1'b0}};
`ifdef DECODE_WB_BYPASS_EN
      else if (wb_en && (wb_addr == rs1_s)) rs1_data_s = wb_data;
`endif
      else rs1_data_s = regs[rs1_s];

      if (rs2_s == 5'd0) rs2_data_s = {XLEN{1'b0}};
`ifdef DECODE_WB_BYPASS_EN
      else if (wb_en && (wb_addr == rs2_s)) rs2_data_s = wb_data;
`endif
      else rs2_data_s = regs[rs2_s];
   end

   // A load in ID/EX blocks any instruction that reads its destination.
   assign hazard_s = valid_r && (ex_r.instr[6:0] == OP_LOAD) && (ex_r.rd != 5'd0) &&
                     ((uses_rs1(kind_s) && (ex_r.rd == rs1_s)) ||
                      (uses_rs2(bus.in_instr[6:0]) && (ex_r.rd == rs2_s)));
   assign advance_s    = !valid_r || bus.out_ready;
   assign bus.in_ready = advance_s && !hazard_s && !flush;

   // Register-file write port; writes to x0 are discarded.
   always_ff @(posedge clk) begin
      if (wb_en && (wb_addr != 5'd0)) regs[wb_addr] <= wb_data;
   end

   // ID/EX register with reset > flush > bubble > load > drain > hold priority.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_r    <= 1'b0;
         ex_r       <= '0;
         pc_r       <= {PC_W{1'b0}};
         target_r   <= {PC_W{1'b0}};
         rs1_data_r <= {XLEN{1'b0}};
         rs2_data_r <= {XLEN{1'b0}};
         imm_r      <= {XLEN{1'b0}};
         stall_r    <= 32'd0;
      end else if (flush) begin
         valid_r <= 1'b0;
      end else if (advance_s && hazard_s) begin
         valid_r <= 1'b0;
         if (stall_r != 32'hFFFF_FFFF) stall_r <= stall_r + 32'd1;
      end else if (advance_s && bus.in_valid) begin
         valid_r     <= 1'b1;
         ex_r.instr  <= bus.in_instr;
         ex_r.rd     <= bus.in_instr[11:7];
         ex_r.rs1    <= rs1_s;
         ex_r.rs2    <= rs2_s;
         ex_r.equal  <= (rs1_data_s == rs2_data_s);
         pc_r        <= bus.in_pc;
         target_r    <= bus.in_pc + imm_s[PC_W-1:0];
         rs1_data_r  <= rs1_data_s;
         rs2_data_r  <= rs2_data_s;
         imm_r       <= imm_s;
      end else if (advance_s) begin
         valid_r <= 1'b0;
      end
   end

   assign bus.out_valid   = valid_r;
   assign bus.ex_pc       = pc_r;
   assign bus.ex_instr    = ex_r.instr;
   assign bus.ex_rs1_data = rs1_data_r;
   assign bus.ex_rs2_data = rs2_data_r;
   assign bus.ex_imm      = imm_r;
   assign bus.ex_rd       = ex_r.rd;
   assign bus.ex_rs1      = ex_r.rs1;
   assign bus.ex_rs2      = ex_r.rs2;
   assign bus.ex_target   = target_r;
   assign bus.ex_equal    = ex_r.equal;
   assign stall_cnt       = stall_r;
endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios then random traffic
// against a cycle-level reference model of the decode rules.
module tb_decode_stage;
   localparam int XLEN = 64;
   localparam int PC_W = 12;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [63:0] wb_data;
   logic        flush;
   logic [31:0] stall_cnt;

   always #5 clk = ~clk;

   decode_if #(.XLEN(XLEN), .PC_W(PC_W)) bus ();

   decode_stage #(.XLEN(XLEN), .PC_W(PC_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .wb_en     (wb_en),
      .wb_addr   (wb_addr),
      .wb_data   (wb_data),
      .flush     (flush),
      .stall_cnt (stall_cnt)
   );

   // Reference model state
   logic [63:0] mregs [32];
   logic        m_valid;
   logic [31:0] m_instr;
   logic [11:0] m_pc;
   logic [63:0] m_rs1d, m_rs2d, m_imm;
   logic [11:0] m_tgt;
   logic        m_eq;
   logic [31:0] m_stall;
   logic        obs_ready;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] ref_imm(input logic [31:0] ins);
      longint v;
      case (ins[6:0])
         7'h03, 7'h13, 7'h67: v = longint'($signed(ins[31:20]));
         7'h23: v = longint'($signed({ins[31:25], ins[11:7]}));
         7'h63: v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
         7'h37, 7'h17: v = longint'($signed(ins[31:12])) * 4096;
         7'h6f: v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
         default: v = 0;
      endcase
      return 64'(v);
   endfunction

   function automatic logic [63:0] ref_read(input logic [4:0] r, input logic we,
                                            input logic [4:0] wa, input logic [63:0] wd);
      if (r == 5'd0) return 64'd0;
`ifdef DECODE_WB_BYPASS_EN
      if (we && wa == r) return wd;
`endif
      return mregs[r];
   endfunction

   function automatic logic uses1(input logic [6:0] op);
      return !(op == 7'h37 || op == 7'h17 || op == 7'h6f);
   endfunction

   function automatic logic uses2(input logic [6:0] op);
      return op == 7'h23 || op == 7'h63 || op == 7'h33;
   endfunction

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_r(input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [4:0] rd);
      return {7'd0, rs2, rs1, 3'd0, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1);
      return {imm[12], imm[10:5], rs2, rs1, 3'd0, imm[4:1], imm[11], 7'b1100011};
   endfunction

   task automatic check_outputs(input string tag);
      chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'(m_valid));
      chk({tag, "_stall_cnt"}, 64'(stall_cnt), 64'(m_stall));
      if (m_valid) begin
         chk({tag, "_ex_pc"}, 64'(bus.ex_pc), 64'(m_pc));
         chk({tag, "_ex_instr"}, 64'(bus.ex_instr), 64'(m_instr));
         chk({tag, "_ex_rs1_data"}, bus.ex_rs1_data, m_rs1d);
         chk({tag, "_ex_rs2_data"}, bus.ex_rs2_data, m_rs2d);
         chk({tag, "_ex_imm"}, bus.ex_imm, m_imm);
         chk({tag, "_ex_rd"}, 64'(bus.ex_rd), 64'(m_instr[11:7]));
         chk({tag, "_ex_rs1"}, 64'(bus.ex_rs1), 64'(m_instr[19:15]));
         chk({tag, "_ex_rs2"}, 64'(bus.ex_rs2), 64'(m_instr[24:20]));
         chk({tag, "_ex_target"}, 64'(bus.ex_target), 64'(m_tgt));
         chk({tag, "_ex_equal"}, 64'(bus.ex_equal), 64'(m_eq));
      end
   endtask

   // One clock: drive inputs, check in_ready, advance the model, check the registered bundle.
   task automatic step(input string tag, input logic v, input logic [31:0] ins,
                       input logic [11:0] pc, input logic ordy, input logic fl,
                       input logic we, input logic [4:0] wa, input logic [63:0] wd);
      logic haz, adv;
      bus.in_valid  = v;
      bus.in_instr  = ins;
      bus.in_pc     = pc;
      bus.out_ready = ordy;
      flush   = fl;
      wb_en   = we;
      wb_addr = wa;
      wb_data = wd;
      #1;
      haz = m_valid && (m_instr[6:0] == 7'h03) && (m_instr[11:7] != 5'd0) &&
            ((uses1(ins[6:0]) && m_instr[11:7] == ins[19:15]) ||
             (uses2(ins[6:0]) && m_instr[11:7] == ins[24:20]));
      adv = !m_valid || ordy;
      obs_ready = bus.in_ready;
      chk({tag, "_in_ready"}, 64'(obs_ready), 64'(adv && !haz && !fl));
      if (fl) m_valid = 1'b0;
      else if (adv && haz) begin
         m_valid = 1'b0;
         if (m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
      end else if (adv && v) begin
         m_valid = 1'b1;
         m_instr = ins;
         m_pc    = pc;
         m_rs1d  = ref_read(ins[19:15], we, wa, wd);
         m_rs2d  = ref_read(ins[24:20], we, wa, wd);
         m_imm   = ref_imm(ins);
         m_tgt   = pc + m_imm[11:0];
         m_eq    = (m_rs1d == m_rs2d);
      end else if (adv) m_valid = 1'b0;
      if (we && wa != 5'd0) mregs[wa] = wd;
      @(posedge clk);
      #1;
      check_outputs(tag);
   endtask

   task automatic issue(input string tag, input logic [31:0] ins, input logic [11:0] pc,
                        input logic ordy, input logic fl);
      step(tag, 1'b1, ins, pc, ordy, fl, 1'b0, 5'd0, 64'd0);
   endtask

   task automatic wb_write(input logic [4:0] wa, input logic [63:0] wd);
      step("wb", 1'b0, 32'd0, 12'd0, 1'b1, 1'b0, 1'b1, wa, wd);
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.in_instr = 32'd0; bus.in_pc = 12'd0; bus.out_ready = 1'b1;
      flush = 1'b0; wb_en = 1'b0; wb_addr = 5'd0; wb_data = 64'd0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      m_valid = 1'b0; m_instr = 32'd0; m_pc = 12'd0; m_rs1d = 64'd0; m_rs2d = 64'd0;
      m_imm = 64'd0; m_tgt = 12'd0; m_eq = 1'b0; m_stall = 32'd0;
      check_outputs(tag);
      chk({tag, "_zero_pc"}, 64'(bus.ex_pc), 64'd0);
      chk({tag, "_zero_instr"}, 64'(bus.ex_instr), 64'd0);
      chk({tag, "_zero_imm"}, bus.ex_imm, 64'd0);
      chk({tag, "_zero_rs1_data"}, bus.ex_rs1_data, 64'd0);
      chk({tag, "_zero_target"}, 64'(bus.ex_target), 64'd0);
      rst = 1'b0;
   endtask

   logic [6:0]  op_tab [9] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h33};
   logic [31:0] ins_a, ins_b, rnd;
   logic [6:0]  rop;

   initial begin
      do_reset("reset");
      for (int r = 1; r < 32; r++) wb_write(5'(r), {$urandom, $urandom});

      issue("addi", 32'h0050_0093, 12'h010, 1'b1, 1'b0);
      chk("addi_imm_const", bus.ex_imm, 64'd5);
      chk("addi_rd_const", 64'(bus.ex_rd), 64'd1);
      chk("addi_rs1_const", bus.ex_rs1_data, 64'd0);

      wb_write(5'd2, 64'h1234);
      wb_write(5'd3, 64'h1234);
      issue("beq", enc_b(13'h1FF8, 5'd3, 5'd2), 12'h004, 1'b1, 1'b0);
      chk("beq_equal_const", 64'(bus.ex_equal), 64'd1);
      chk("beq_target_const", 64'(bus.ex_target), 64'hFFC);
      chk("beq_imm_const", bus.ex_imm, 64'hFFFF_FFFF_FFFF_FFF8);

      issue("ld", enc_i(12'd0, 5'd1, 3'b011, 5'd5, 7'h03), 12'h020, 1'b1, 1'b0);
      issue("add_stall", enc_r(5'd5, 5'd5, 5'd6), 12'h024, 1'b1, 1'b0);
      chk("ld_use_ready_const", 64'(obs_ready), 64'd0);
      chk("ld_use_bubble_const", 64'(bus.out_valid), 64'd0);
      chk("ld_use_stall_const", 64'(stall_cnt), 64'd1);
      issue("add_issue", enc_r(5'd5, 5'd5, 5'd6), 12'h024, 1'b1, 1'b0);
      chk("add_issue_rd_const", 64'(bus.ex_rd), 64'd6);

      ins_a = enc_i(12'h07F, 5'd4, 3'd0, 5'd10, 7'h13);
      ins_b = enc_r(5'd2, 5'd3, 5'd11);
      issue("hold_load", ins_a, 12'h030, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) begin
         issue("hold", ins_b, 12'h034, 1'b0, 1'b0);
         chk("hold_ready_const", 64'(obs_ready), 64'd0);
         chk("hold_instr_const", 64'(bus.ex_instr), 64'(ins_a));
      end
      issue("flush", ins_b, 12'h034, 1'b0, 1'b1);
      chk("flush_valid_const", 64'(bus.out_valid), 64'd0);
      step("post_flush", 1'b0, 32'd0, 12'd0, 1'b1, 1'b0, 1'b0, 5'd0, 64'd0);

      wb_write(5'd7, 64'h1111);
      step("bypass", 1'b1, enc_r(5'd0, 5'd7, 5'd8), 12'h040, 1'b1, 1'b0, 1'b1, 5'd7, 64'hDEAD);
`ifdef DECODE_WB_BYPASS_EN
      chk("bypass_rs1_const", bus.ex_rs1_data, 64'hDEAD);
`else
      chk("bypass_rs1_const", bus.ex_rs1_data, 64'h1111);
`endif

      wb_write(5'd0, 64'hFF);
      issue("x0_read", enc_r(5'd0, 5'd0, 5'd9), 12'h044, 1'b1, 1'b0);
      chk("x0_rs1_const", bus.ex_rs1_data, 64'd0);
      chk("x0_equal_const", 64'(bus.ex_equal), 64'd1);

      issue("stall_load", ins_a, 12'h050, 1'b1, 1'b0);
      issue("stall_hold", ins_b, 12'h054, 1'b0, 1'b0);
      do_reset("mid_stall_reset");

      for (int n = 0; n < 400; n++) begin
         rnd = $urandom_range(0, 9);
         rop = (rnd == 32'd9) ? 7'($urandom) : op_tab[rnd];
         ins_a = $urandom;
         ins_a[6:0]   = rop;
         ins_a[11:7]  = 5'($urandom_range(0, 7));
         ins_a[19:15] = 5'($urandom_range(0, 7));
         ins_a[24:20] = 5'($urandom_range(0, 7));
         step("rand", ($urandom_range(0, 4) != 0), ins_a, 12'($urandom),
              ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
              ($urandom_range(0, 1) != 0), 5'($urandom_range(0, 7)), {$urandom, $urandom});
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised RISC-V instruction-decode stage with an internal ID/EX pipeline register, a valid/ready handshake on both sides, load-use interlock and flush. It generates immediates and branch/jump targets and compares register operands. It owns the architectural register file. It sits between the fetch stage and the execute stage and supersedes the earlier unregistered decode path.

## Interface
- `XLEN`, 64: data and register width.
- `PC_W`, 12: program-counter width.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  fetch presents an instruction.
- `in_ready`  out  1  decode accepts the instruction this cycle.
- `in_instr`  in  32  instruction word.
- `in_pc`  in  PC_W  instruction address.
- `wb_en`, `wb_addr[4:0]`, `wb_data[XLEN]`  in  register-file write port.
- `flush`  in  1  kill the instruction in ID and the ID/EX register.
- `out_valid`  out  1  ID/EX register holds a valid instruction.
- `out_ready`  in  1  execute consumes the ID/EX contents.
- `ex_pc[PC_W]`, `ex_instr[32]`, `ex_rs1_data[XLEN]`, `ex_rs2_data[XLEN]`, `ex_imm[XLEN]`, `ex_rd/ex_rs1/ex_rs2[5]`, `ex_target[PC_W]`, `ex_equal[1]`  out  registered decode bundle.
- `stall_cnt`  out  32  count of load-use bubbles inserted.

## Operation
- Register file: 32 x XLEN. x0 reads 0, and writes to x0 are ignored. The file is written on the rising edge when `wb_en`.
- Fields: rd=[11:7], rs1=[19:15], rs2=[24:20].
- Immediate generation uses opcode [6:0] and sign-extends to XLEN:
  - I: 0000011, 0010011, 1100111.
  - S: 0100011.
  - B: 1100011, with bit0=0 and no extra shift.
  - U: 0110111, 0010111.
  - J: 1101111.
  - All other opcodes give 0.
- Target = in_pc + imm[PC_W-1:0], modulo 2^PC_W. Wrap-around is silent.
- Equal = (rs1 operand == rs2 operand) over the full XLEN.
- Operand use:
  - rs1 is used by all opcodes except U and J.
  - rs2 is used by S, B and R (0110011).
- Load-use hazard: out_valid, and ex_instr opcode = 0000011, and ex_rd != 0, and ex_rd equals a used rs1 or rs2 of in_instr.
- advance = !out_valid | out_ready.
- in_ready = advance & !hazard & !flush.
- Update priority on each rising edge:
  1. rst: out_valid=0, all ex_* and stall_cnt = 0.
  2. flush: out_valid=0, and the ID instruction is dropped.
  3. advance & hazard: bubble. out_valid=0 and stall_cnt+1 (saturating at 2^32-1).
  4. advance & in_valid: load the bundle and set out_valid=1.
  5. advance & !in_valid: out_valid=0.
  6. Otherwise hold every ex_* output stable.
- A hazard produces exactly one bubble, because the load leaves the ID/EX register.
- No writeback to EX forwarding happens here. Execute owns EX/MEM forwarding.

## Timing
- Latency: 1 cycle from an accepted in_valid&in_ready to out_valid.
- Throughput: 1 instruction per cycle when there is no hazard and out_ready is high.
- in_ready is combinational from in_instr, ID/EX state, out_ready and flush.
- A writeback and a decode of the same register in the same cycle are resolved per Configuration.
- A flush while out_ready=0 still clears out_valid.
- Asserting rst mid-stall discards the held bundle.

## Configuration
- `DECODE_WB_BYPASS_EN`:
  - Defined: if wb_en & wb_addr!=0 & wb_addr matches rs1 or rs2, then wb_data replaces that read value in the same cycle. This covers the captured operands and the Equal compare.
  - Undefined: the raw register read returns the pre-write value. Software needs a 3-instruction gap for WB-to-ID RAW.

## Structure
- Package `decode_pkg` holds:
  - opcode localparams (OP_LOAD, OP_IMM, OP_JALR, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_REG).
  - typedef enum `imm_kind_t` {IMM_NONE, I, S, B, U, J}.
  - typedef struct `id_ex_t` for the registered bundle.
- Sub-module `imm_gen`: combinational, produces the opcode-to-imm_kind_t decode and the XLEN sign-extension.
- The register file is inside decode_stage.

## Test plan
- Reset, then in_instr=0x00500093 (addi x1,x0,5), pc=0x010 -> next cycle out_valid=1, ex_imm=5, ex_rd=1, ex_rs1_data=0.
- Write x2=0x1234 and x3=0x1234, then decode beq x2,x3,-8 at pc=0x004 -> ex_equal=1, ex_target=0xFFC (wrap), ex_imm=-8.
- ld x5,0(x1), then add x6,x5,x5 back-to-back -> one bubble (out_valid=0 for one cycle), in_ready=0 for that cycle, stall_cnt=1, add issues next.
- out_ready=0 for 3 cycles while an instruction is held -> ex_* stable, in_ready=0. Then flush=1 -> out_valid=0 next cycle, and the input instruction is not captured.
- Same-cycle wb_en x7=0xDEAD and decode of add x8,x7,x0 -> ex_rs1_data=0xDEAD with `DECODE_WB_BYPASS_EN` defined, and the old value without it.
- wb_en to x0 with 0xFF, then decode reading x0 -> data 0.
